// File: rtl/multicycle_controller.sv
// Multicycle RV32-style control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes and selects, flags illegal opcodes with a
// sticky trap and counts retired instructions (cycles with PCWrite).
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  Opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [1:0]  ALUOp,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [1:0]  PCSel,
    output logic [1:0]  WBSel,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MEM    = 4'd3,
        WB     = 4'd4,
        BRANCH = 4'd5,
        JUMP   = 4'd6,
        TRAP   = 4'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t      state_q, state_d;
    logic [6:0]  opc_q, opc_d;
    logic        illegal_q;
    logic [31:0] instret_q;

    logic is_r, is_i, is_load, is_store, is_lui, is_auipc, is_br, is_jal, is_jalr;

    assign is_r     = (opc_q == OP_R);
    assign is_i     = (opc_q == OP_I);
    assign is_load  = (opc_q == OP_LOAD);
    assign is_store = (opc_q == OP_STORE);
    assign is_lui   = (opc_q == OP_LUI);
    assign is_auipc = (opc_q == OP_AUIPC);
    assign is_br    = (opc_q == OP_BR);
    assign is_jal   = (opc_q == OP_JAL);
    assign is_jalr  = (opc_q == OP_JALR);

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

    // Next-state and strobe decode; everything is forced low while reset is held
    // so strobes drop the moment reset asserts, not at the next edge.
    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        ALUOp    = 2'b00;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        PCSel    = 2'b00;
        WBSel    = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    opc_d   = Opcode;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_r || is_i || is_load || is_store || is_lui || is_auipc)
                    state_d = EXEC;
                else if (is_br)
                    state_d = BRANCH;
                else if (is_jal || is_jalr)
                    state_d = JUMP;
                else
                    state_d = TRAP;
            end
            EXEC: begin
                ALUOp   = is_r ? 2'b10 : (is_i ? 2'b11 : 2'b00);
                ALUSrcB = !is_r;
                ALUSrcA = is_auipc;
                state_d = (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        PCWrite = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                WBSel    = is_load ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUOp   = 2'b01;
                PCWrite = 1'b1;
                PCSel   = branch_taken ? 2'b01 : 2'b00;
                state_d = FETCH;
            end
            JUMP: begin
                RegWrite = 1'b1;
                WBSel    = 2'b10;
                PCWrite  = 1'b1;
                PCSel    = is_jalr ? 2'b11 : 2'b10;
                state_d  = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
        if (!reset) begin
            ALUOp    = 2'b00;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 1'b0;
            PCSel    = 2'b00;
            WBSel    = 2'b00;
        end
    end

    // State, latched opcode, sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            opc_q     <= '0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_q | (state_d == TRAP);
            instret_q <= instret_q + {31'd0, PCWrite};
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  Opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic [1:0]  ALUOp;
    logic        IRWrite, PCWrite, MemRead, MemWrite, RegWrite, ALUSrcA, ALUSrcB;
    logic [1:0]  PCSel, WBSel;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instret;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ALUOp(ALUOp), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSel(PCSel), .WBSel(WBSel), .state(state), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] JUNK = 7'b1111111;

    // per-cycle stimulus plus the expected packed control word
    // packed word: {state, IR, PCW, MR, MW, RW, ASA, ASB, PCSel, WBSel, ALUOp}
    typedef struct packed {
        logic        mr;
        logic        bt;
        logic [6:0]  op;
        logic [16:0] exp;
    } step_t;

    step_t       sbq[$];
    step_t       s;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_instret = '0;

    function automatic logic [16:0] obs();
        return {state, IRWrite, PCWrite, MemRead, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
                PCSel, WBSel, ALUOp};
    endfunction

    // strobes: {IR, PCW, MR, MW, RW, ASA, ASB}
    function automatic void push(input logic mr, input logic bt, input logic [6:0] op,
                                 input logic [3:0] st, input logic [6:0] strobes,
                                 input logic [1:0] pcsel, input logic [1:0] wbsel,
                                 input logic [1:0] aluop);
        step_t t;
        t.mr  = mr;
        t.bt  = bt;
        t.op  = op;
        t.exp = {st, strobes, pcsel, wbsel, aluop};
        sbq.push_back(t);
        if (strobes[5]) exp_instret = exp_instret + 32'd1;
    endfunction

    // FETCH with memory ready, then DECODE while the opcode bus carries junk
    function automatic void push_fd(input logic [6:0] op);
        push(1'b1, 1'b0, op,   4'd0, 7'b1010000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK, 4'd1, 7'b0000000, 2'b00, 2'b00, 2'b00);
    endfunction

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0; Opcode = 7'b0110011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs() !== 17'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected %h", obs(), 17'd0);
        end
        n_cmp++;
        if (instret !== 32'd0) begin
            n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret);
        end
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_instret = '0;
    endtask

    task automatic test_alu();
        // R, I, LUI, AUIPC: FETCH DECODE EXEC WB
        push_fd(7'b0110011);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000000, 2'b00, 2'b00, 2'b10);
        push(1'b1, 1'b0, JUNK, 4'd4, 7'b0100100, 2'b00, 2'b00, 2'b00);
        push_fd(7'b0010011);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000001, 2'b00, 2'b00, 2'b11);
        push(1'b1, 1'b0, JUNK, 4'd4, 7'b0100100, 2'b00, 2'b00, 2'b00);
        push_fd(7'b0110111);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK, 4'd4, 7'b0100100, 2'b00, 2'b11, 2'b00);
        push_fd(7'b0010111);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000011, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK, 4'd4, 7'b0100100, 2'b00, 2'b00, 2'b00);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL alu_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL alu_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_load_stall();
        // fetch stalls one cycle, MEM stalls two: 8 cycles total
        push(1'b0, 1'b0, 7'b0000011, 4'd0, 7'b0010000, 2'b00, 2'b00, 2'b00);
        push_fd(7'b0000011);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00);
        push(1'b0, 1'b0, JUNK, 4'd3, 7'b0010000, 2'b00, 2'b00, 2'b00);
        push(1'b0, 1'b0, JUNK, 4'd3, 7'b0010000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK, 4'd3, 7'b0010000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK, 4'd4, 7'b0100100, 2'b00, 2'b01, 2'b00);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL load_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL load_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_store_jump();
        push_fd(7'b0100011);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK, 4'd3, 7'b0101000, 2'b00, 2'b00, 2'b00);
        push_fd(7'b1101111);
        push(1'b1, 1'b0, JUNK, 4'd6, 7'b0100100, 2'b10, 2'b10, 2'b00);
        push_fd(7'b1100111);
        push(1'b1, 1'b0, JUNK, 4'd6, 7'b0100100, 2'b11, 2'b10, 2'b00);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL store_jump_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL store_jump_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_back_to_back();
        // branch_taken is ignored outside BRANCH, so toggle it in DECODE too
        push(1'b1, 1'b0, 7'b1100011, 4'd0, 7'b1010000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK,       4'd1, 7'b0000000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b1, JUNK,       4'd5, 7'b0100000, 2'b01, 2'b00, 2'b01);
        push(1'b1, 1'b1, 7'b1100011, 4'd0, 7'b1010000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b1, JUNK,       4'd1, 7'b0000000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, JUNK,       4'd5, 7'b0100000, 2'b00, 2'b00, 2'b01);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL branch_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL branch_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_trap();
        push(1'b1, 1'b0, 7'b0000000, 4'd0, 7'b1010000, 2'b00, 2'b00, 2'b00);
        push(1'b1, 1'b0, 7'b0110011, 4'd1, 7'b0000000, 2'b00, 2'b00, 2'b00);
        for (int unsigned i = 0; i < 11; i++)
            push(1'b1, 1'b1, 7'b0110011, 4'd7, 7'b0000000, 2'b00, 2'b00, 2'b00);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL trap_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (illegal !== 1'b1) begin
            n_fail++; $display("FAIL trap_illegal: got %b expected 1", illegal);
        end
        n_cmp++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL trap_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_reset_mid_mem();
        // leave TRAP through reset
        reset = 1'b0; #1;
        n_cmp++;
        if (illegal !== 1'b0 || state !== 4'd0) begin
            n_fail++; $display("FAIL trap_exit: got illegal=%b state=%0d expected 0/0", illegal, state);
        end
        exp_instret = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        // store stalled in MEM with MemWrite high
        push_fd(7'b0100011);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000001, 2'b00, 2'b00, 2'b00);
        push(1'b0, 1'b0, JUNK, 4'd3, 7'b0001000, 2'b00, 2'b00, 2'b00);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL midmem_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        // still in MEM here; assert reset between edges
        mem_ready = 1'b0;
        reset = 1'b0; #1;
        exp_instret = '0;
        n_cmp++;
        if (obs() !== 17'd0) begin
            n_fail++; $display("FAIL midmem_reset_ctrl: got %h expected %h", obs(), 17'd0);
        end
        n_cmp++;
        if (instret !== 32'd0) begin
            n_fail++; $display("FAIL midmem_reset_instret: got %0d expected 0", instret);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        // normal R-type after release
        push_fd(7'b0110011);
        push(1'b1, 1'b0, JUNK, 4'd2, 7'b0000000, 2'b00, 2'b00, 2'b10);
        push(1'b1, 1'b0, JUNK, 4'd4, 7'b0100100, 2'b00, 2'b00, 2'b00);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            mem_ready = s.mr; branch_taken = s.bt; Opcode = s.op;
            @(negedge clk);
            n_cmp++;
            if (obs() !== s.exp) begin
                n_fail++; $display("FAIL post_reset_seq: got %h expected %h", obs(), s.exp);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL post_reset_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load_stall();
        test_store_jump();
        test_back_to_back();
        test_trap();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
